// File: rtl/iob_cache_be_mem.sv
// ============================================================================
// Module  : iob_cache_be_mem
// Brief   : Multi-channel cache back-end memory, round-robin arbitrated,
//           byte-writable shared RAM with configurable access latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_cache_be_mem #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              ch_valid,
  input  logic [N_CH*ADDR_W-1:0]       ch_addr,
  input  logic [N_CH*DATA_W-1:0]       ch_wdata,
  input  logic [N_CH*(DATA_W/8)-1:0]   ch_wstrb,
  output logic [N_CH*DATA_W-1:0]       ch_rdata,
  output logic [N_CH-1:0]              ch_ready,
  output logic                         busy,
  output logic [$clog2(N_CH):0]        grant
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = $clog2(NBYTES);
  localparam int MEM_W  = ADDR_W - BYTE_W;
  localparam int DEPTH  = 2 ** MEM_W;
  localparam int IDX_W  = $clog2(N_CH) + 1;
  localparam int CNT_W  = 5;

  if (N_CH < 1 || N_CH > 8) begin : g_chk_nch
    $error("iob_cache_be_mem: N_CH must be in 1..8");
  end
  if (LATENCY < 1 || LATENCY > 16) begin : g_chk_lat
    $error("iob_cache_be_mem: LATENCY must be in 1..16");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_chk_dw
    $error("iob_cache_be_mem: DATA_W must be a non-zero multiple of 8");
  end
  if (ADDR_W <= BYTE_W) begin : g_chk_aw
    $error("iob_cache_be_mem: ADDR_W too small for DATA_W");
  end

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               is_wr_q, is_wr_d;
  logic [DATA_W-1:0]  hold_q;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [MEM_W-1:0]   sel_word;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NBYTES-1:0]  sel_wstrb;
  logic               ram_we;
  logic               ram_re;
  logic               done;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Round-robin: first requester strictly above the pointer, else wrap to the lowest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!sel_found && ch_valid[i] && (IDX_W'(i) > rr_q)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!sel_found && ch_valid[i] && (IDX_W'(i) <= rr_q)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_word  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_word  = ch_addr[i*ADDR_W+BYTE_W +: MEM_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = ch_wstrb[i*NBYTES +: NBYTES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      rr_q    <= IDX_W'(N_CH - 1);
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      is_wr_q <= is_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    is_wr_d = is_wr_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_W'(LATENCY - 1);
          grant_d = sel_idx;
          rr_d    = sel_idx;
          is_wr_d = |sel_wstrb;
          ram_we  = |sel_wstrb;
          ram_re  = ~|sel_wstrb;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Writes land on the grant edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (sel_wstrb[b]) begin
          mem[sel_word][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (ram_re) begin
      hold_q <= mem[sel_word];
    end
  end

  assign done  = (state_q == S_ACCESS) && (cnt_q == '0);
  assign busy  = (state_q == S_ACCESS);
  assign grant = grant_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        rdata_q <= '0;
      end else if (done && !is_wr_q && (grant_q == IDX_W'(i))) begin
        rdata_q <= hold_q;
      end
    end

    // Read data is visible in the ready cycle itself, then held per channel.
    assign ch_ready[i] = done && (grant_q == IDX_W'(i));
    assign ch_rdata[i*DATA_W +: DATA_W] = (ch_ready[i] && !is_wr_q) ? hold_q : rdata_q;
  end

endmodule

`default_nettype wire
